// File: rtl/afe_lfsr_toa_tot.sv
// AFE readout block: TOA/TOT measurement with 8-bit LFSR counters, SPI mode-0 slave
// for readout and configuration, sticky hit flag and a selectable debug bus.
`timescale 1ns/1ps
module afe_lfsr_toa_tot #(
  parameter logic [7:0]  SEED        = 8'hFF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCLK,
  input  logic       CS_B,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       INJ_IN,
  input  logic       INJ_IN_DEL,
  input  logic       COMP,
  output logic       HIT,
  output logic [7:0] GPIO
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    TOA_RUN = 3'd2,
    TOT_RUN = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int unsigned NIN    = 6;
  localparam int unsigned I_SCLK = 0;
  localparam int unsigned I_CS   = 1;
  localparam int unsigned I_MOSI = 2;
  localparam int unsigned I_INJ  = 3;
  localparam int unsigned I_DEL  = 4;
  localparam int unsigned I_COMP = 5;

  logic [NIN-1:0] async_in;
  logic [NIN-1:0] sync_pipe [SYNC_STAGES];
  logic [NIN-1:0] s;
  // Previous-cycle copies of the edge-detected inputs: {COMP, DEL, INJ, CS, SCLK}
  logic [4:0]     prev;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic inj_rise, del_rise, comp_rise, comp_fall;

  state_t      state, state_nxt;
  logic [7:0]  toa_q, tot_q;
  logic        hit_q;
  logic [15:0] shift_q;
  logic [7:0]  rx_q;
  logic [7:0]  cfg_q;
  logic [5:0]  bits_q;
  logic [7:0]  gpio_q;
  logic        enter_tot;
  logic        spi_clr;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  assign async_in = {COMP, INJ_IN_DEL, INJ_IN, MOSI, CS_B, SCLK};

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= '0;
      prev <= '0;
    end else begin
      sync_pipe[0] <= async_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
      prev <= {s[I_COMP], s[I_DEL], s[I_INJ], s[I_CS], s[I_SCLK]};
    end
  end

  assign s = sync_pipe[SYNC_STAGES-1];

  assign sclk_rise =  s[I_SCLK] & ~prev[0];
  assign sclk_fall = ~s[I_SCLK] &  prev[0];
  assign cs_rise   =  s[I_CS]   & ~prev[1];
  assign cs_fall   = ~s[I_CS]   &  prev[1];
  assign inj_rise  =  s[I_INJ]  & ~prev[2];
  assign del_rise  =  s[I_DEL]  & ~prev[3];
  assign comp_rise =  s[I_COMP] & ~prev[4];
  assign comp_fall = ~s[I_COMP] &  prev[4];

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (inj_rise) begin
      state_nxt = ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (del_rise && comp_rise) state_nxt = TOT_RUN;
          else if (del_rise)         state_nxt = TOA_RUN;
        end
        TOA_RUN: if (comp_rise) state_nxt = TOT_RUN;
        TOT_RUN: if (comp_fall) state_nxt = DONE;
        default: ;
      endcase
    end
  end

  assign enter_tot = (state_nxt == TOT_RUN) && (state != TOT_RUN);

  // Counters step on every cycle spent in their run state, so the count equals
  // the number of clocks between the synchronized start and stop edges.
  always_ff @(posedge CLK) begin
    if (RST || inj_rise) begin
      toa_q <= SEED;
      tot_q <= SEED;
    end else begin
      if (state == TOA_RUN) toa_q <= lfsr_step(toa_q);
      if (state == TOT_RUN) tot_q <= lfsr_step(tot_q);
    end
  end

  assign spi_clr = cs_rise && cfg_q[2] && (state == DONE) && (bits_q >= 6'd16);

  always_ff @(posedge CLK) begin
    if (RST || inj_rise) hit_q <= 1'b0;
    else if (enter_tot)  hit_q <= 1'b1;
    else if (spi_clr)    hit_q <= 1'b0;
  end

  // MISO is the shift MSB; clearing the shifter at frame end forces it low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q <= '0;
      rx_q    <= '0;
      cfg_q   <= '0;
      bits_q  <= '0;
    end else if (cs_fall) begin
      shift_q <= {toa_q, tot_q};
      bits_q  <= '0;
    end else if (cs_rise) begin
      if (bits_q >= 6'd8) cfg_q <= rx_q;
      shift_q <= '0;
    end else if (!s[I_CS]) begin
      if (sclk_rise) begin
        rx_q <= {rx_q[6:0], s[I_MOSI]};
        if (bits_q != '1) bits_q <= bits_q + 6'd1;
      end
      if (sclk_fall) shift_q <= {shift_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      gpio_q <= '0;
    end else begin
      case (cfg_q[1:0])
        2'b00:   gpio_q <= {1'b0, state, hit_q, s[I_COMP], s[I_DEL], s[I_INJ]};
        2'b01:   gpio_q <= toa_q;
        2'b10:   gpio_q <= tot_q;
        default: gpio_q <= cfg_q;
      endcase
    end
  end

  assign MISO = shift_q[15];
  assign HIT  = hit_q;
  assign GPIO = gpio_q;

endmodule

// File: tb/tb_afe_lfsr_toa_tot.sv
// Self-checking bench for afe_lfsr_toa_tot: clock-aligned stimulus, LFSR sequence table model.
`timescale 1ns/1ps
module tb_afe_lfsr_toa_tot;

  logic       CLK = 1'b0;
  logic       RST, SCLK, CS_B, MOSI, MISO, INJ_IN, INJ_IN_DEL, COMP, HIT;
  logic [7:0] GPIO;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] cfg_m;
  logic [7:0] seq [255];

  afe_lfsr_toa_tot #(.SEED(8'hFF), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .CS_B(CS_B), .MOSI(MOSI), .MISO(MISO),
    .INJ_IN(INJ_IN), .INJ_IN_DEL(INJ_IN_DEL), .COMP(COMP), .HIT(HIT), .GPIO(GPIO)
  );

  always #12.5 CLK = ~CLK;

  function automatic logic [7:0] lfsr_after(input int n);
    return seq[n % 255];
  endfunction

  task automatic clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // 8 CLK per SCLK bit; returns MISO bits sampled just before each SCLK rise.
  task automatic spi_xfer(input int nbits, input logic [31:0] tx, output logic [31:0] rx);
    rx = '0;
    CS_B = 1'b0;
    clk(6);
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[nbits-1-i];
      clk(4);
      rx = {rx[30:0], MISO};
      SCLK = 1'b1;
      clk(4);
      SCLK = 1'b0;
    end
    MOSI = 1'b0;
    clk(4);
    CS_B = 1'b1;
    clk(6);
  endtask

  task automatic write_cfg(input logic [7:0] b);
    logic [31:0] r;
    spi_xfer(8, {24'h0, b}, r);
    cfg_m = b;
  endtask

  task automatic read16(output logic [15:0] d);
    logic [31:0] r;
    spi_xfer(16, {16'h0, 8'h00, cfg_m}, r);
    d = r[15:0];
  endtask

  task automatic measure(input int n, input int m, input bit same);
    INJ_IN = 1'b1;
    clk(3);
    INJ_IN = 1'b0;
    clk(4);
    INJ_IN_DEL = 1'b1;
    if (same) begin
      COMP = 1'b1;
    end else begin
      clk(n);
      COMP = 1'b1;
    end
    clk(m);
    COMP = 1'b0;
    clk(6);
    INJ_IN_DEL = 1'b0;
    clk(2);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    checks++; if (HIT !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", HIT); end
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", MISO); end
    checks++; if (GPIO !== 8'h00) begin errors++; $display("FAIL reset_gpio got %h exp 00", GPIO); end
    read16(d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL reset_read got %h exp FFFF", d); end
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso_after got %b exp 0", MISO); end
  endtask

  task automatic test_cfg_write();
    logic [31:0] r;
    write_cfg(8'h00);
    checks++; if (GPIO !== 8'h00) begin errors++; $display("FAIL cfg_zero got %h exp 00", GPIO); end
    write_cfg(8'hA3);
    checks++; if (GPIO !== 8'hA3) begin errors++; $display("FAIL cfg_mode3 got %h exp A3", GPIO); end
    spi_xfer(5, 32'h1F, r);
    checks++; if (GPIO !== 8'hA3) begin errors++; $display("FAIL cfg_short_frame got %h exp A3", GPIO); end
    write_cfg(8'h01);
    checks++; if (GPIO !== 8'hFF) begin errors++; $display("FAIL cfg_mode1_toa got %h exp FF", GPIO); end
  endtask

  task automatic test_measure_basic();
    logic [15:0] d;
    logic [7:0]  et, eo;
    et = lfsr_after(12);
    eo = lfsr_after(21);
    measure(12, 21, 1'b0);
    checks++; if (GPIO !== et) begin errors++; $display("FAIL basic_gpio_toa got %h exp %h", GPIO, et); end
    read16(d);
    checks++; if (d[15:8] !== et) begin errors++; $display("FAIL basic_toa got %h exp %h", d[15:8], et); end
    checks++; if (d[7:0] !== eo) begin errors++; $display("FAIL basic_tot got %h exp %h", d[7:0], eo); end
    checks++; if (HIT !== 1'b1) begin errors++; $display("FAIL basic_hit got %b exp 1", HIT); end
    write_cfg(8'h02);
    checks++; if (GPIO !== eo) begin errors++; $display("FAIL basic_gpio_tot got %h exp %h", GPIO, eo); end
  endtask

  task automatic test_same_cycle();
    logic [15:0] d;
    logic [7:0]  eo;
    eo = lfsr_after(15);
    measure(0, 15, 1'b1);
    read16(d);
    checks++; if (d[15:8] !== 8'hFF) begin errors++; $display("FAIL same_toa got %h exp FF", d[15:8]); end
    checks++; if (d[7:0] !== eo) begin errors++; $display("FAIL same_tot got %h exp %h", d[7:0], eo); end
    checks++; if (HIT !== 1'b1) begin errors++; $display("FAIL same_hit got %b exp 1", HIT); end
  endtask

  task automatic test_rearm();
    logic [15:0] d;
    logic [7:0]  eg;
    write_cfg(8'h00);
    INJ_IN = 1'b1; clk(3); INJ_IN = 1'b0; clk(4);
    INJ_IN_DEL = 1'b1; clk(5);
    COMP = 1'b1; clk(5);
    checks++; if (HIT !== 1'b1) begin errors++; $display("FAIL rearm_hit_before got %b exp 1", HIT); end
    INJ_IN = 1'b1; clk(6);
    eg = {1'b0, 3'd1, 1'b0, COMP, INJ_IN_DEL, INJ_IN};
    checks++; if (HIT !== 1'b0) begin errors++; $display("FAIL rearm_hit got %b exp 0", HIT); end
    checks++; if (GPIO !== eg) begin errors++; $display("FAIL rearm_gpio got %h exp %h", GPIO, eg); end
    read16(d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL rearm_read got %h exp FFFF", d); end
    INJ_IN = 1'b0; COMP = 1'b0; INJ_IN_DEL = 1'b0;
    clk(6);
  endtask

  task automatic test_read_during_run();
    logic [31:0] r;
    logic [15:0] d;
    logic [7:0]  et, eo;
    INJ_IN = 1'b1; clk(3); INJ_IN = 1'b0; clk(4);
    INJ_IN_DEL = 1'b1; clk(20);
    // 32-bit frame lasts 16 + 8*32 = 272 clocks; COMP rises 300 clocks after INJ_IN_DEL.
    spi_xfer(32, {24'h0, cfg_m}, r);
    checks++; if (r[31:24] !== lfsr_after(19) && r[31:24] !== lfsr_after(20)) begin
      errors++; $display("FAIL run_snap_toa got %h exp %h or %h", r[31:24], lfsr_after(19), lfsr_after(20));
    end
    checks++; if (r[23:16] !== 8'hFF) begin errors++; $display("FAIL run_snap_tot got %h exp FF", r[23:16]); end
    checks++; if (r[15:0] !== 16'h0000) begin errors++; $display("FAIL run_tail_bits got %h exp 0000", r[15:0]); end
    clk(8);
    COMP = 1'b1; clk(10); COMP = 1'b0; clk(6); INJ_IN_DEL = 1'b0; clk(2);
    et = lfsr_after(300);
    eo = lfsr_after(10);
    read16(d);
    checks++; if (d[15:8] !== et) begin errors++; $display("FAIL run_final_toa got %h exp %h", d[15:8], et); end
    checks++; if (d[7:0] !== eo) begin errors++; $display("FAIL run_final_tot got %h exp %h", d[7:0], eo); end
  endtask

  task automatic test_hit_clear();
    logic [15:0] d;
    write_cfg(8'h04);
    measure(5, 7, 1'b0);
    checks++; if (HIT !== 1'b1) begin errors++; $display("FAIL clr_hit_set got %b exp 1", HIT); end
    write_cfg(8'h04);
    checks++; if (HIT !== 1'b1) begin errors++; $display("FAIL clr_short_keeps got %b exp 1", HIT); end
    read16(d);
    checks++; if (HIT !== 1'b0) begin errors++; $display("FAIL clr_hit_cleared got %b exp 0", HIT); end
    checks++; if (d !== {lfsr_after(5), lfsr_after(7)}) begin
      errors++; $display("FAIL clr_read got %h exp %h", d, {lfsr_after(5), lfsr_after(7)});
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [7:0]  eg;
    int n, m, mode;
    for (int k = 0; k < 6; k++) begin
      n    = $urandom_range(1, 300);
      m    = $urandom_range(1, 80);
      mode = $urandom_range(1, 2);
      write_cfg(8'(mode));
      measure(n, m, 1'b0);
      eg = (mode == 1) ? lfsr_after(n) : lfsr_after(m);
      checks++; if (GPIO !== eg) begin errors++; $display("FAIL rand_gpio n=%0d m=%0d got %h exp %h", n, m, GPIO, eg); end
      read16(d);
      checks++; if (d !== {lfsr_after(n), lfsr_after(m)}) begin
        errors++; $display("FAIL rand_read n=%0d m=%0d got %h exp %h", n, m, d, {lfsr_after(n), lfsr_after(m)});
      end
      checks++; if (HIT !== 1'b1) begin errors++; $display("FAIL rand_hit got %b exp 1", HIT); end
    end
  endtask

  initial begin
    seq[0] = 8'hFF;
    for (int i = 1; i < 255; i++)
      seq[i] = {seq[i-1][6:0], seq[i-1][7] ^ seq[i-1][5] ^ seq[i-1][4] ^ seq[i-1][3]};
    cfg_m = 8'h00;
    RST = 1'b1; CS_B = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    INJ_IN = 1'b0; INJ_IN_DEL = 1'b0; COMP = 1'b0;
    clk(3);
    RST = 1'b0;
    clk(6);
    test_reset();
    test_cfg_write();
    test_measure_basic();
    test_same_cycle();
    test_rearm();
    test_read_during_run();
    test_hit_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
